// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, step encoding and elaboration/compare helpers
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
    localparam int MAX_DIGITS = 9;
    localparam int BCD_MAX_W = BCD_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2
    } step_op_e;

    function automatic longint pow10(input int digits);
        longint r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [BCD_MAX_W-1:0] to_bcd(input int value, input int digits);
        logic [BCD_MAX_W-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [BCD_MAX_W-1:0] a, input int digits);
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && a[BCD_W*i +: BCD_W] > BCD_NINE) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Most significant digit decides first; equal digits fall through to the next one.
    function automatic logic bcd_le(input logic [BCD_MAX_W-1:0] a, input logic [BCD_MAX_W-1:0] b);
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (a[BCD_W*i +: BCD_W] < b[BCD_W*i +: BCD_W]) begin
                return 1'b1;
            end
            if (a[BCD_W*i +: BCD_W] > b[BCD_W*i +: BCD_W]) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// rtl/bcd_updown_counter_if.sv - control inputs and status outputs of the BCD counter
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
) ();

    logic                  clr;
    logic                  cnt_i;
    logic                  down_i;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   value_bcd;
    logic                  at_zero;
    logic                  at_max;
    logic                  limit;
    logic                  load_err;
    logic [3:0]            led;

    modport master (
        output clr, cnt_i, down_i, load, load_value,
        input  value_bcd, at_zero, at_max, limit, load_err, led
    );

    modport slave (
        input  clr, cnt_i, down_i, load, load_value,
        output value_bcd, at_zero, at_max, limit, load_err, led
    );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit of the ripple chain; cin_i enables the step at this digit
module bcd_digit
    import bcd_pkg::*;
(
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              cin_i,
    input  logic [BCD_W-1:0]  digit_i,
    output logic [BCD_W-1:0]  digit_o,
    output logic              cout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i && inc_i) begin
            if (digit_i >= BCD_NINE) begin
                digit_o = '0;
                cout_o  = 1'b1;
            end else begin
                digit_o = digit_i + BCD_W'(1);
            end
        end else if (cin_i && dec_i) begin
            if (digit_i == '0) begin
                digit_o = BCD_NINE;
                cout_o  = 1'b1;
            end else begin
                digit_o = digit_i - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - N-digit BCD up/down counter with edge-detected step, clear, load, modulus
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int MAX_VALUE     = 9999,
    parameter bit WRAP          = 1'b1,
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_updown_counter_if.slave  bus
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [BCD_MAX_W-1:0] MAX_BCD_FULL = to_bcd(MAX_VALUE, DIGITS);
    localparam logic [W-1:0] MAX_BCD = MAX_BCD_FULL[W-1:0];

    if (DIGITS < 1 || DIGITS > MAX_DIGITS || MAX_VALUE < 0 ||
        longint'(MAX_VALUE) >= pow10(DIGITS)) begin : g_bad_params
        $error("bcd_updown_counter: MAX_VALUE must fit in DIGITS decimal digits");
    end

    logic [W-1:0] value_q, value_d;
    logic         limit_q, limit_d;
    logic         load_err_q, load_err_d;
    logic         cnt_q;
    logic         armed_q, armed_d;

    logic         cnt_a, cnt_q_a, dn_a, step;
    logic         at_zero_w, at_max_w, load_ok;
    step_op_e     op;
    logic [W-1:0] value_step;
    logic [DIGITS:0] carry;

    assign cnt_a   = bus.cnt_i ^ ACTIVE_LOW_IN;
    assign cnt_q_a = cnt_q ^ ACTIVE_LOW_IN;
    assign dn_a    = bus.down_i ^ ACTIVE_LOW_IN;

    // A level held asserted across reset must not count: stepping is armed only
    // after a de-asserted sample has been seen since reset.
    assign armed_d = armed_q | ~cnt_a;
    assign step    = cnt_a & ~cnt_q_a & armed_q;

    assign at_zero_w = (value_q == '0);
    assign at_max_w  = (value_q == MAX_BCD);
    assign load_ok   = bcd_valid(BCD_MAX_W'(bus.load_value), DIGITS) &&
                       bcd_le(BCD_MAX_W'(bus.load_value), MAX_BCD_FULL);

    always_comb begin
        op = OP_NONE;
        if (step) begin
            op = dn_a ? OP_DEC : OP_INC;
        end
    end

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .inc_i   (op == OP_INC),
            .dec_i   (op == OP_DEC),
            .cin_i   (carry[i]),
            .digit_i (value_q[BCD_W*i +: BCD_W]),
            .digit_o (value_step[BCD_W*i +: BCD_W]),
            .cout_o  (carry[i+1])
        );
    end

    // Carry/borrow out of the top digit also marks a boundary, so the chain can never roll silently.
    always_comb begin
        value_d    = value_q;
        limit_d    = 1'b0;
        load_err_d = 1'b0;
        if (bus.clr) begin
            value_d = '0;
        end else if (bus.load) begin
            if (load_ok) begin
                value_d = bus.load_value;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (op)
                OP_INC: begin
                    if (at_max_w || carry[DIGITS]) begin
                        limit_d = 1'b1;
                        if (WRAP) begin
                            value_d = '0;
                        end
                    end else begin
                        value_d = value_step;
                    end
                end
                OP_DEC: begin
                    if (at_zero_w || carry[DIGITS]) begin
                        limit_d = 1'b1;
                        if (WRAP) begin
                            value_d = MAX_BCD;
                        end
                    end else begin
                        value_d = value_step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= '0;
            limit_q    <= 1'b0;
            load_err_q <= 1'b0;
            cnt_q      <= ACTIVE_LOW_IN;
            armed_q    <= 1'b0;
        end else begin
            value_q    <= value_d;
            limit_q    <= limit_d;
            load_err_q <= load_err_d;
            cnt_q      <= bus.cnt_i;
            armed_q    <= armed_d;
        end
    end

    assign bus.value_bcd = value_q;
    assign bus.at_zero   = at_zero_w;
    assign bus.at_max    = at_max_w;
    assign bus.limit     = limit_q;
    assign bus.load_err  = load_err_q;
    assign bus.led       = ~value_q[3:0];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - scoreboard bench driving three counter configurations in parallel
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        clr = 1'b0;
    logic        cnt = 1'b1;
    logic        dn  = 1'b1;
    logic        ld  = 1'b0;
    logic [15:0] lv  = 16'h0;

    bcd_updown_counter_if #(.DIGITS(4)) if0 ();
    bcd_updown_counter_if #(.DIGITS(4)) if1 ();
    bcd_updown_counter_if #(.DIGITS(3)) if2 ();

    assign if0.clr = clr; assign if0.cnt_i = cnt; assign if0.down_i = dn;
    assign if0.load = ld; assign if0.load_value = lv;
    assign if1.clr = clr; assign if1.cnt_i = cnt; assign if1.down_i = dn;
    assign if1.load = ld; assign if1.load_value = lv;
    assign if2.clr = clr; assign if2.cnt_i = cnt; assign if2.down_i = dn;
    assign if2.load = ld; assign if2.load_value = lv[11:0];

    bcd_updown_counter #(.DIGITS(4), .MAX_VALUE(9999), .WRAP(1'b1), .ACTIVE_LOW_IN(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    bcd_updown_counter #(.DIGITS(4), .MAX_VALUE(9999), .WRAP(1'b0), .ACTIVE_LOW_IN(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    bcd_updown_counter #(.DIGITS(3), .MAX_VALUE(250), .WRAP(1'b1), .ACTIVE_LOW_IN(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    // Reference: decimal integer value per configuration, plus the last normalised count sample.
    int k_dig  [3] = '{4, 4, 3};
    int k_max  [3] = '{9999, 9999, 250};
    bit k_wrap [3] = '{1'b1, 1'b0, 1'b1};
    int m_val  [3] = '{0, 0, 0};
    bit m_prev = 1'b1;

    logic [23:0] q0[$];
    logic [23:0] q1[$];
    logic [23:0] q2[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] pack_exp(input int k, input int v, input bit lim, input bit err);
        logic [15:0] b;
        b = int2bcd(v);
        return {b, v == 0, v == k_max[k], lim, err, ~b[3:0]};
    endfunction

    function automatic logic [23:0] act(input int k);
        case (k)
            0: return {if0.value_bcd, if0.at_zero, if0.at_max, if0.limit, if0.load_err, if0.led};
            1: return {if1.value_bcd, if1.at_zero, if1.at_max, if1.limit, if1.load_err, if1.led};
            default: return {4'h0, if2.value_bcd, if2.at_zero, if2.at_max, if2.limit, if2.load_err, if2.led};
        endcase
    endfunction

    task automatic push(input int k, input logic [23:0] e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [23:0] a, input logic [23:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got {bcd,z,m,lim,err,led}=%h want %h", name, $time, a, e);
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cyc(input bit c, input bit d, input bit cl, input bit l, input logic [15:0] v);
        bit ca, stp, lim, err, ok;
        int dec, dg;
        logic [15:0] lvk;
        cnt = c; dn = d; clr = cl; ld = l; lv = v;
        ca = ~c;
        stp = ca & ~m_prev;
        m_prev = ca;
        for (int k = 0; k < 3; k++) begin
            lim = 1'b0;
            err = 1'b0;
            if (cl) begin
                m_val[k] = 0;
            end else if (l) begin
                lvk = (k_dig[k] == 3) ? {4'h0, v[11:0]} : v;
                ok = 1'b1;
                dec = 0;
                for (int i = k_dig[k] - 1; i >= 0; i--) begin
                    dg = int'(lvk[4*i +: 4]);
                    if (dg > 9) ok = 1'b0;
                    dec = dec * 10 + dg;
                end
                if (ok && dec <= k_max[k]) m_val[k] = dec;
                else err = 1'b1;
            end else if (stp) begin
                if (!d) begin
                    if (m_val[k] == 0) begin
                        lim = 1'b1;
                        if (k_wrap[k]) m_val[k] = k_max[k];
                    end else begin
                        m_val[k] = m_val[k] - 1;
                    end
                end else begin
                    if (m_val[k] == k_max[k]) begin
                        lim = 1'b1;
                        if (k_wrap[k]) m_val[k] = 0;
                    end else begin
                        m_val[k] = m_val[k] + 1;
                    end
                end
            end
            push(k, pack_exp(k, m_val[k], lim, err));
        end
        @(negedge clk);
    endtask

    task automatic press(input bit d);
        cyc(1'b0, d, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, d, 1'b0, 1'b0, 16'h0);
    endtask

    // Reset is raised between edges so its asynchronous effect is checked before any clock.
    task automatic do_reset(input bit c);
        cnt = c; clr = 1'b0; ld = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst", act(k), pack_exp(k, 0, 1'b0, 1'b0));
            m_val[k] = 0;
            push(k, pack_exp(k, 0, 1'b0, 1'b0));
        end
        m_prev = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q0.size() > 0) chk("u0_wrap4", act(0), q0.pop_front());
            if (q1.size() > 0) chk("u1_sat4", act(1), q1.pop_front());
            if (q2.size() > 0) chk("u2_mod250", act(2), q2.pop_front());
        end
    end

    initial begin
        int r;
        bit rc, rd, rcl, rl;
        logic [15:0] rv;

        @(negedge clk);
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 12; i++) press(1'b1);

        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h9998);
        press(1'b1);
        press(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        press(1'b0);
        press(1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0251);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0250);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h01A0);

        for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0109);
        press(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h1000);
        press(1'b0);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 5; i++) press(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        press(1'b1);

        for (int n = 0; n < 2500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                rc  = 1'($urandom_range(0, 1));
                rd  = 1'($urandom_range(0, 1));
                rcl = ($urandom_range(0, 31) == 0);
                rl  = ($urandom_range(0, 11) == 0);
                case ($urandom_range(0, 3))
                    0: rv = int2bcd(int'($urandom_range(0, 9999)));
                    1: rv = int2bcd(int'($urandom_range(9990, 9999)));
                    2: rv = int2bcd(int'($urandom_range(240, 260)));
                    default: rv = 16'($urandom);
                endcase
                cyc(rc, rd, rcl, rl, rv);
            end
        end

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending %0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
